fetch_stage: RTL

Instruction-fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the IF/ID pipeline register and drives its IF_PC/IF_Instruction inputs. Owns the 12-bit PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and absorbs hazard-unit stalls and EX-stage branch/jump redirects. Produces a valid flag so bubbles into IF/ID are explicit NOPs.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_skid.sv | 34 +++
 rtl/fetch_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32 pipeline.
// Holds fetch FSM encoding and default widths.
package riscv_pkg;

  localparam int          DEF_PC_WIDTH  = 12;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry PC+instruction buffer.
// Parks a returned word while IF/ID is stalled.
module fetch_skid
  import riscv_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [31:0]         instr_in,
  output logic                valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instr
);

  // Clear dominates load so a redirect always empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= DEF_NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage, owns the PC and the imem handshake.
// Feeds IF/ID with registered PC/instruction/valid.
module fetch_stage #(
  parameter int                PC_WIDTH  = riscv_pkg::DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INSTR = riscv_pkg::DEF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] IF_PC,
  output logic [31:0]         IF_Instruction,
  output logic                IF_Valid
);
  import riscv_pkg::*;

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target;
  logic                take;
  logic                skid_load;
  logic                skid_clear;
  logic                skid_valid;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [31:0]         skid_instr;
  logic                unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign target     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign pc_inc     = pc + PC_WIDTH'(4);
  assign take       = (state == WAIT) && imem_rvalid;

  assign imem_req  = !rst && (state == FETCH);
  assign imem_addr = pc;

  assign skid_load  = take && stall && !redirect;
  assign skid_clear = redirect || ((state == HOLD) && !stall);

  fetch_skid #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  // Next state and PC; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect) begin
      pc_nxt = target;
      unique case (1'b1)
        (state == WAIT)  && !imem_rvalid: state_nxt = DRAIN;
        (state == FETCH) && imem_gnt:     state_nxt = DRAIN;
        (state == DRAIN) && !imem_rvalid: state_nxt = DRAIN;
        default:                          state_nxt = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: if (imem_gnt) state_nxt = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            pc_nxt    = pc_inc;
            state_nxt = stall ? HOLD : FETCH;
          end
        end
        HOLD:  if (!stall) state_nxt = FETCH;
        DRAIN: if (imem_rvalid) state_nxt = FETCH;
      endcase
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // IF/ID-facing output register; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_PC          <= '0;
      IF_Instruction <= NOP_INSTR;
      IF_Valid       <= 1'b0;
    end else if (redirect) begin
      IF_Instruction <= NOP_INSTR;
      IF_Valid       <= 1'b0;
    end else if (!stall) begin
      if (take) begin
        IF_PC          <= pc;
        IF_Instruction <= imem_rdata;
        IF_Valid       <= 1'b1;
      end else if ((state == HOLD) && skid_valid) begin
        IF_PC          <= skid_pc;
        IF_Instruction <= skid_instr;
        IF_Valid       <= 1'b1;
      end else begin
        IF_Instruction <= NOP_INSTR;
        IF_Valid       <= 1'b0;
      end
    end
  end

endmodule
